fd_tick_gen: RTL and testbench

- Parametrised, fully synchronous successor to the ripple-toggle frequency divider.
- Generates NUM_CH independent divided timebases from the single system clock. Each channel has a runtime-programmable divisor and provides two outputs: a one-cycle clock-enable pulse (tick) and a toggling square-wave level.
- Feeds the 7-segment refresh and station-timing logic with enables, so no derived clocks are needed.

---
 rtl/fd_pkg.sv | 18 +
 rtl/fd_channel.sv | 72 +++++++
 rtl/fd_tick_gen.sv | 72 +++++++
 tb/tb_fd_tick_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - shared constants, types and helpers for the fd_tick_gen divider
package fd_pkg;

  // Default counter/divisor width used when a module is not overridden
  localparam int FD_CNT_W_DEFAULT = 26;

  // Upper bound on the number of divider channels
  localparam int FD_MAX_CH = 16;

  // Divisor word at the default width; instances with other widths use their own CNT_W
  typedef logic [FD_CNT_W_DEFAULT-1:0] fd_div_t;

  // Channel-select width for n channels; never narrower than one bit
  function automatic int fd_ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fd_channel.sv
// rtl/fd_channel.sv - one divider channel: divisor register, counter, tick and level flops
module fd_channel
  import fd_pkg::*;
#(
  parameter int          CNT_W       = FD_CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 65536
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             adv_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic             tick_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             level_q, level_d;

  // Next state: clear beats load beats advance; a divisor write survives a clear
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    level_d = level_q;
    if (ld_i) begin
      div_d = ld_val_i;
    end
    if (clr_i || ld_i) begin
      cnt_d   = ZERO;
      level_d = 1'b0;
    end else if (div_q == ZERO) begin
      // Disabled channel: counter parked at zero, level frozen
      cnt_d = ZERO;
    end else if (adv_i) begin
      // div-1 is taken in CNT_W bits; div_q is nonzero here so it never wraps
      if (cnt_q == (div_q - ONE)) begin
        cnt_d   = ZERO;
        tick_d  = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= DIV_RST;
      cnt_q   <= ZERO;
      tick_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
    end
  end

  assign tick_o  = tick_q;
  assign level_o = level_q;

endmodule

// File: rtl/fd_tick_gen.sv
// rtl/fd_tick_gen.sv - NUM_CH-channel tick/level generator; FD_CASCADE_EN chains the channels
module fd_tick_gen
  import fd_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = FD_CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 65536,
  parameter int          CH_W        = fd_ch_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              clear,
  input  logic              div_load,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]  div_value,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level
);

  logic [31:0]       sel_ext;
  logic [NUM_CH-1:0] adv_vec;
  logic [NUM_CH-1:0] ld_vec;
  logic [NUM_CH-1:0] clr_vec;

  assign sel_ext = 32'(ch_sel);

  // Per-channel load decode; an out-of-range select matches no channel
  always_comb begin
    ld_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ld_vec[k] = div_load && (sel_ext == 32'(k));
    end
  end

`ifdef FD_CASCADE_EN
  // Chained advance: channel k counts ticks of channel k-1; a load re-aligns every later channel
  always_comb begin
    adv_vec    = '0;
    clr_vec    = '0;
    adv_vec[0] = run;
    clr_vec[0] = clear;
    for (int k = 1; k < NUM_CH; k++) begin
      adv_vec[k] = run && tick[k-1];
      clr_vec[k] = clear || (div_load && (sel_ext < 32'(k)));
    end
  end
`else
  // Independent advance: every channel counts on run alone
  always_comb begin
    adv_vec = {NUM_CH{run}};
    clr_vec = {NUM_CH{clear}};
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fd_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .adv_i    (adv_vec[g]),
      .clr_i    (clr_vec[g]),
      .ld_i     (ld_vec[g]),
      .ld_val_i (div_value),
      .tick_o   (tick[g]),
      .level_o  (level[g])
    );
  end

endmodule

// File: tb/tb_fd_tick_gen.sv
// tb/tb_fd_tick_gen.sv - randomized self-checking bench for fd_tick_gen against an arithmetic model
module tb_fd_tick_gen;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              run;
  logic              clear;
  logic              div_load;
  logic [CH_W-1:0]   ch_sel;
  logic [CNT_W-1:0]  div_value;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;

  int total = 0;
  int bad   = 0;

  // Model: advancing cycles since last reset/clear/load, divisor, last tick
  int m_adv_cnt [NUM_CH];
  int m_div     [NUM_CH];
  bit m_tick    [NUM_CH];
  logic [NUM_CH-1:0] exp_tick;
  logic [NUM_CH-1:0] exp_level;

  fd_tick_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .CH_W        (CH_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .clear     (clear),
    .div_load  (div_load),
    .ch_sel    (ch_sel),
    .div_value (div_value),
    .tick      (tick),
    .level     (level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_outputs();
    for (int k = 0; k < NUM_CH; k++) begin
      exp_tick[k]  = m_tick[k];
      // level has toggled once per completed divisor period
      exp_level[k] = (m_div[k] != 0) ? (((m_adv_cnt[k] / m_div[k]) % 2) == 1) : 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_adv_cnt[k] = 0;
      m_div[k]     = DEFAULT_DIV;
      m_tick[k]    = 1'b0;
    end
    model_outputs();
  endtask

  task automatic model_step(input bit r, input bit c, input bit l, input int s, input int v);
    bit prev_tick [NUM_CH];
    bit adv;
    bit chain_rst;
    for (int k = 0; k < NUM_CH; k++) prev_tick[k] = m_tick[k];
    for (int k = 0; k < NUM_CH; k++) begin
      adv       = r;
      chain_rst = 1'b0;
`ifdef FD_CASCADE_EN
      if (k > 0) adv = r && prev_tick[k-1];
      chain_rst = l && (s < k);
`endif
      if (l && s == k) m_div[k] = v;
      if (c || (l && s == k) || chain_rst) begin
        m_adv_cnt[k] = 0;
        m_tick[k]    = 1'b0;
      end else if (adv && m_div[k] != 0) begin
        m_adv_cnt[k]++;
        m_tick[k] = (m_adv_cnt[k] % m_div[k]) == 0;
      end else begin
        m_tick[k] = 1'b0;
      end
    end
    model_outputs();
  endtask

  task automatic cycle(input bit r, input bit c, input bit l, input int s, input int v);
    run       = r;
    clear     = c;
    div_load  = l;
    ch_sel    = CH_W'(s);
    div_value = CNT_W'(v);
    model_step(r, c, l, s, v);
    @(posedge clock);
    #1;
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("level", 32'(level), 32'(exp_level));
  endtask

  initial begin
    reset_n   = 1'b0;
    run       = 1'b1;
    clear     = 1'b0;
    div_load  = 1'b0;
    ch_sel    = '0;
    div_value = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    reset_n = 1'b1;

    // Default divisor: ticks at 4, 8, 12 advancing cycles
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a count
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    @(posedge clock);
    #1;
    chk("arst_hold_tick", 32'(tick), 32'd0);
    model_reset();
    reset_n = 1'b1;

    // Divisor 1 on channel 1, then divisor 0
    cycle(1, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);

    // run dropped for 3 cycles with channel 0 at count 2
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);

    // Load on channel 0 coinciding with its terminal count, then out-of-range select
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 3);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 3, 7);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0);

    // Clear mid-count keeps divisors
    cycle(1, 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0);

    // clear together with a load: counters cleared, divisor written
    cycle(1, 1, 1, 2, 2);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);

    // div0=4, div1=3 (chained product 12 under cascade build)
    cycle(1, 0, 1, 0, 4);
    cycle(1, 0, 1, 1, 3);
    cycle(1, 0, 1, 0, 4);
    for (int i = 0; i < 30; i++) cycle(1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, c, l;
      r = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 19) == 0);
      cycle(r, c, l, $urandom_range(0, 3), $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
